// File: rtl/pin_reset_sequencer.sv
// rtl/pin_reset_sequencer.sv - pin motor reset sequencer with bounded retries and fault latch
//
// Purpose: on start, drives the pin motor for PULL_CYCLES, waits SETTLE_CYCLES
// with the motor off, then checks all three pin sensors. Any pin down retries the
// pull up to MAX_RETRY extra times before latching FAULT until clear.
// Optional feature: define PIN_SYNC_EN to pass pin_state through a two-flop
// synchronizer before the check uses it.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   request a pin reset (sampled in IDLE only)
//   clear      in   acknowledge a fault (sampled in FAULT only)
//   pin_state  in   [2:0] per-pin sensor, 1 = pin standing
//   motor_en   out  pin motor drive, high in PULL
//   record_en  out  score recording permitted, high in IDLE
//   busy       out  high in PULL, SETTLE, CHECK
//   done       out  one-cycle pulse after a successful check
//   fault      out  high in FAULT
//   retry_cnt  out  [1:0] retries used in the current sequence
module pin_reset_sequencer #(
   parameter int PULL_CYCLES   = 160000000,
   parameter int SETTLE_CYCLES = 300000000,
   parameter int MAX_RETRY     = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       clear,
   input  logic [2:0] pin_state,
   output logic       motor_en,
   output logic       record_en,
   output logic       busy,
   output logic       done,
   output logic       fault,
   output logic [1:0] retry_cnt
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PULL   = 3'd1,
      SETTLE = 3'd2,
      CHECK  = 3'd3,
      FAULT  = 3'd4
   } state_t;

   localparam logic [31:0] PULL_LAST   = 32'(PULL_CYCLES - 1);
   localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
   localparam logic [1:0]  RETRY_MAX   = 2'(MAX_RETRY);

   state_t      state;
   state_t      state_nxt;
   logic [31:0] cnt;
   logic [31:0] cnt_nxt;
   logic [1:0]  retry_nxt;
   logic        done_nxt;
   logic [2:0]  pins_chk;

`ifdef PIN_SYNC_EN
   logic [2:0] pin_meta;
   logic [2:0] pin_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pin_meta <= 3'b000;
         pin_sync <= 3'b000;
      end else begin
         pin_meta <= pin_state;
         pin_sync <= pin_meta;
      end
   end

   assign pins_chk = pin_sync;
`else
   assign pins_chk = pin_state;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 32'd0;
         retry_cnt <= 2'd0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         retry_cnt <= retry_nxt;
         done      <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      retry_nxt = retry_cnt;
      done_nxt  = 1'b0;
      cnt_nxt   = 32'd0;

      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = PULL;
               retry_nxt = 2'd0;
            end
         end
         PULL: begin
            if (cnt == PULL_LAST) state_nxt = SETTLE;
         end
         SETTLE: begin
            if (cnt == SETTLE_LAST) state_nxt = CHECK;
         end
         CHECK: begin
            if (pins_chk == 3'b111) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end else if (retry_cnt < RETRY_MAX) begin
               state_nxt = PULL;
               retry_nxt = retry_cnt + 2'd1;
            end else begin
               state_nxt = FAULT;
            end
         end
         FAULT: begin
            // start is deliberately not looked at here, even alongside clear
            if (clear) begin
               state_nxt = IDLE;
               retry_nxt = 2'd0;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Counter restarts from zero on every state entry, including CHECK -> PULL.
      if (state_nxt != state) begin
         cnt_nxt = 32'd0;
      end else if (state == PULL || state == SETTLE) begin
         cnt_nxt = cnt + 32'd1;
      end
   end

   // Decoded from the state register only; async reset drops motor_en at once.
   assign motor_en  = (state == PULL);
   assign record_en = (state == IDLE);
   assign busy      = (state == PULL) || (state == SETTLE) || (state == CHECK);
   assign fault     = (state == FAULT);

endmodule
